booth_mult_seq: RTL

- Parametrised, iterative radix-4 Booth multiplier. Successor to the 16x16 single-cycle booth16x16_top.
- Trades single-cycle combinational depth for one partial-product step per clock.
- Adds a valid/ready handshake on input and output and is width-generic.
- Sits between the ALU operand registers and the writeback mux. Keeps the same result/flag semantics: signed/unsigned select, neg_flag, zero_flag.

---
 rtl/booth_mult_seq.sv | 121 ++++++++++++
 1 files changed

// File: rtl/booth_mult_seq.sv
// Iterative radix-4 Booth multiplier with valid/ready handshakes, one partial product per clock.
// Optional macro BOOTH_EARLY_ZERO_EN: a zero operand skips CALC and goes straight to DONE.
module booth_mult_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 alu_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   PROD_RESULT,
  output logic                 neg_flag,
  output logic                 zero_flag
);

  localparam int ITER = WIDTH/2 + 1;
  localparam int AW   = 2*WIDTH + 4;
  localparam int CW   = $clog2(ITER + 1);
`ifdef BOOTH_EARLY_ZERO_EN
  localparam bit EARLY_ZERO = 1'b1;
`else
  localparam bit EARLY_ZERO = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_next;
  logic [AW-1:0]   acc, mcand, pp, acc_sum, a_ext;
  logic [WIDTH+2:0] mplier, b_ext;
  logic [CW-1:0]   iter_cnt;
  logic            signed_q;
  logic            accept, last_iter, zero_operand;

  assign accept       = in_valid && in_ready;
  assign last_iter    = (iter_cnt == CW'(ITER - 1));
  assign zero_operand = EARLY_ZERO && ((A == '0) || (B == '0));

  // Multiplier carries an appended 0 at the bottom so bits [2:0] are always the current triplet.
  assign a_ext   = {{(AW-WIDTH){alu_signed & A[WIDTH-1]}}, A};
  assign b_ext   = {{2{alu_signed & B[WIDTH-1]}}, B, 1'b0};
  assign acc_sum = acc + pp;

  always_comb begin
    pp = '0;
    case (mplier[2:0])
      3'b001, 3'b010: pp = mcand;
      3'b011:         pp = mcand << 1;
      3'b100:         pp = -(mcand << 1);
      3'b101, 3'b110: pp = -mcand;
      default:        pp = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = zero_operand ? DONE : CALC;
      CALC:    if (last_iter) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
  end

  // Multiplicand shifts left by two each step so the addend lands at weight 4^i.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      iter_cnt    <= '0;
      signed_q    <= 1'b0;
      PROD_RESULT <= '0;
      neg_flag    <= 1'b0;
      zero_flag   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc      <= '0;
            mcand    <= a_ext;
            mplier   <= b_ext;
            iter_cnt <= '0;
            signed_q <= alu_signed;
            if (zero_operand) begin
              PROD_RESULT <= '0;
              neg_flag    <= 1'b0;
              zero_flag   <= 1'b1;
            end
          end
        end
        CALC: begin
          acc      <= acc_sum;
          mcand    <= mcand << 2;
          mplier   <= mplier >> 2;
          iter_cnt <= iter_cnt + CW'(1);
          if (last_iter) begin
            PROD_RESULT <= acc_sum[2*WIDTH-1:0];
            neg_flag    <= signed_q & acc_sum[2*WIDTH-1];
            zero_flag   <= (acc_sum[2*WIDTH-1:0] == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
